mem_bus_arbiter: RTL and testbench

//   Shares the single-port data_mem between two masters: the core EX stage (m0) and an

---
 rtl/mem_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - data_mem arbiter: core priority, starvation-forced ext bursts.
// Optional MEM_ARB_PERF_CNT_EN builds the hold/wait performance counters.
module mem_bus_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int STARVE_MAX    = 4,
    parameter int EXT_BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              core_hold_o,
    input  logic              ext_req_i,
    input  logic              ext_we_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,
    output logic              ext_gnt_o,
    output logic              ext_rvalid_o,
    output logic [DATA_W-1:0] ext_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [31:0]       perf_hold_cnt_o,
    output logic [31:0]       perf_wait_cnt_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(EXT_BURST_MAX + 1);

    typedef enum logic {S_CORE, S_EXT} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            ext_rvalid_q, ext_rvalid_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic            core_own, ext_own;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_CORE;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            S_CORE: begin
                burst_cnt_d = '0;
                if (ext_req_i && core_req_i) begin
                    if (starve_cnt_q == SW'(STARVE_MAX - 1)) begin
                        state_d      = S_EXT;
                        starve_cnt_d = '0;
                    end else begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end
            default: begin
                starve_cnt_d = '0;
                // The grant that would bring the count to EXT_BURST_MAX ends the burst.
                if (!ext_req_i || burst_cnt_q == BW'(EXT_BURST_MAX - 1)) begin
                    state_d     = S_CORE;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Ownership is forced to none while reset is asserted so the memory sees no access.
    always_comb begin
        core_own     = 1'b0;
        ext_own      = 1'b0;
        core_hold_o  = (state_q == S_EXT);
        if (rst) begin
            if (state_q == S_CORE) begin
                core_own = core_req_i;
                ext_own  = !core_req_i && ext_req_i;
            end else begin
                ext_own  = ext_req_i;
            end
        end
        ext_gnt_o    = ext_own;
        mem_req_o    = core_own || ext_own;
        mem_we_o     = 1'b0;
        mem_waddr_o  = '0;
        mem_raddr_o  = '0;
        mem_wdata_o  = '0;
        core_rdata_o = '0;
        if (core_own) begin
            mem_we_o     = core_we_i;
            mem_waddr_o  = core_addr_i;
            mem_raddr_o  = core_addr_i;
            mem_wdata_o  = core_wdata_i;
            core_rdata_o = core_we_i ? '0 : mem_rdata_i;
        end else if (ext_own) begin
            mem_we_o     = ext_we_i;
            mem_waddr_o  = ext_addr_i;
            mem_raddr_o  = ext_addr_i;
            mem_wdata_o  = ext_wdata_i;
        end
    end

    always_comb begin
        ext_rvalid_d = ext_own && !ext_we_i;
        ext_rdata_d  = ext_rvalid_d ? mem_rdata_i : ext_rdata_q;
    end

    assign ext_rvalid_o = ext_rvalid_q;
    assign ext_rdata_o  = ext_rdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_hold_q, perf_hold_d;
    logic [31:0] perf_wait_q, perf_wait_d;

    always_comb begin
        perf_hold_d = perf_hold_q;
        perf_wait_d = perf_wait_q;
        if (core_hold_o && perf_hold_q != 32'hFFFF_FFFF)
            perf_hold_d = perf_hold_q + 32'd1;
        if (ext_req_i && !ext_gnt_o && perf_wait_q != 32'hFFFF_FFFF)
            perf_wait_d = perf_wait_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_hold_q <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_hold_q <= perf_hold_d;
            perf_wait_q <= perf_wait_d;
        end
    end

    assign perf_hold_cnt_o = perf_hold_q;
    assign perf_wait_cnt_o = perf_wait_q;
`else
    assign perf_hold_cnt_o = 32'h0;
    assign perf_wait_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

    localparam int STARVE_MAX    = 4;
    localparam int EXT_BURST_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req_i = 0, core_we_i = 0;
    logic [31:0] core_addr_i = 0, core_wdata_i = 0;
    logic [31:0] core_rdata_o;
    logic        core_hold_o;
    logic        ext_req_i = 0, ext_we_i = 0;
    logic [31:0] ext_addr_i = 0, ext_wdata_i = 0;
    logic        ext_gnt_o, ext_rvalid_o;
    logic [31:0] ext_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_waddr_o, mem_raddr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = 0;
    logic [31:0] perf_hold_cnt_o, perf_wait_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase flag plus plain integer tallies.
    bit          m_burst;
    int          m_losses, m_grants;
    bit          m_rvalid;
    logic [31:0] m_rdata;
    longint      m_hold, m_wait;

    int          exp_own;  // 0 none, 1 core, 2 ext
    bit          exp_hold, exp_gnt, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_crd, exp_perf_hold, exp_perf_wait;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .EXT_BURST_MAX(EXT_BURST_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o), .core_hold_o(core_hold_o),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
        .ext_wdata_i(ext_wdata_i), .ext_gnt_o(ext_gnt_o), .ext_rvalid_o(ext_rvalid_o),
        .ext_rdata_o(ext_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_waddr_o(mem_waddr_o), .mem_raddr_o(mem_raddr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .perf_hold_cnt_o(perf_hold_cnt_o),
        .perf_wait_cnt_o(perf_wait_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_burst = 0; m_losses = 0; m_grants = 0;
        m_rvalid = 0; m_rdata = 0; m_hold = 0; m_wait = 0;
    endtask

    task automatic compute_perf();
`ifdef MEM_ARB_PERF_CNT_EN
        exp_perf_hold = (m_hold > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_hold[31:0];
        exp_perf_wait = (m_wait > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_wait[31:0];
`else
        exp_perf_hold = 32'h0;
        exp_perf_wait = 32'h0;
`endif
    endtask

    // Apply one cycle of inputs (called just after a rising edge) and predict outputs.
    task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input bit er, input bit ew, input logic [31:0] ea, input logic [31:0] ed,
                         input logic [31:0] rd);
        core_req_i = cr; core_we_i = cw; core_addr_i = ca; core_wdata_i = cd;
        ext_req_i = er; ext_we_i = ew; ext_addr_i = ea; ext_wdata_i = ed; mem_rdata_i = rd;
        exp_own = 0;
        if (rst) begin
            if (!m_burst) exp_own = cr ? 1 : (er ? 2 : 0);
            else          exp_own = er ? 2 : 0;
        end
        exp_hold  = rst && m_burst;
        exp_gnt   = (exp_own == 2);
        exp_req   = (exp_own != 0);
        exp_we    = (exp_own == 1) ? cw : (exp_own == 2) ? ew : 1'b0;
        exp_addr  = (exp_own == 1) ? ca : (exp_own == 2) ? ea : 32'h0;
        exp_wdata = (exp_own == 1) ? cd : (exp_own == 2) ? ed : 32'h0;
        exp_crd   = (exp_own == 1 && !cw) ? rd : 32'h0;
        compute_perf();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_hold += exp_hold;
            m_wait += (ext_req_i && exp_own != 2);
            m_rvalid = (exp_own == 2) && !ext_we_i;
            if (m_rvalid) m_rdata = mem_rdata_i;
            if (!m_burst) begin
                if (core_req_i && ext_req_i) begin
                    m_losses++;
                    if (m_losses == STARVE_MAX) begin m_burst = 1; m_losses = 0; end
                end else m_losses = 0;
            end else if (ext_req_i) begin
                m_grants++;
                if (m_grants == EXT_BURST_MAX) begin m_burst = 0; m_grants = 0; end
            end else begin
                m_burst = 0; m_grants = 0;
            end
        end
        compute_perf();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        drive(1'($urandom), 1'($urandom), $urandom, $urandom,
              1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
        n_checks++;
        if ({core_hold_o, ext_gnt_o, ext_rvalid_o, mem_req_o, mem_we_o} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got hold=%b gnt=%b rvalid=%b req=%b we=%b want all 0",
                     core_hold_o, ext_gnt_o, ext_rvalid_o, mem_req_o, mem_we_o);
        end
        n_checks++;
        if ({mem_waddr_o, mem_raddr_o, mem_wdata_o, ext_rdata_o} !== 128'h0) begin
            n_errors++;
            $display("FAIL reset_data: got waddr=%h raddr=%h wdata=%h rdata=%h want 0",
                     mem_waddr_o, mem_raddr_o, mem_wdata_o, ext_rdata_o);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_core_read();
        drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 32'hDEADBEEF);
        n_checks++;
        if (mem_raddr_o !== 32'h10 || core_rdata_o !== 32'hDEADBEEF || core_hold_o !== 1'b0) begin
            n_errors++;
            $display("FAIL core_read: got raddr=%h rdata=%h hold=%b want 10 deadbeef 0",
                     mem_raddr_o, core_rdata_o, core_hold_o);
        end
        tick();
    endtask

    task automatic test_ext_read();
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0, 32'h1234);
        n_checks++;
        if (ext_gnt_o !== 1'b1 || mem_raddr_o !== 32'h20) begin
            n_errors++;
            $display("FAIL ext_read_gnt: got gnt=%b raddr=%h want 1 20", ext_gnt_o, mem_raddr_o);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h5555);
        n_checks++;
        if (ext_rvalid_o !== 1'b1 || ext_rdata_o !== 32'h1234) begin
            n_errors++;
            $display("FAIL ext_read_data: got rvalid=%b rdata=%h want 1 1234", ext_rvalid_o, ext_rdata_o);
        end
        tick();
        n_checks++;
        if (ext_rvalid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL ext_read_rvalid_drop: got %b want 0", ext_rvalid_o);
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            drive(1, 1'($urandom), $urandom, $urandom, 1, 1'($urandom), $urandom, $urandom, $urandom);
            n_checks++;
            if (core_hold_o !== ((c % 12) >= 4) || ext_gnt_o !== ((c % 12) >= 4)) begin
                n_errors++;
                $display("FAIL contention_c%0d: got hold=%b gnt=%b want %b", c, core_hold_o,
                         ext_gnt_o, ((c % 12) >= 4));
            end
            tick();
        end
        n_checks++;
        if (perf_hold_cnt_o !== exp_perf_hold || exp_perf_hold !== perf_hold_cnt_o) begin
            n_errors++;
            $display("FAIL contention_perf_hold: got %0d want %0d", perf_hold_cnt_o, exp_perf_hold);
        end
`ifdef MEM_ARB_PERF_CNT_EN
        n_checks++;
        if (perf_hold_cnt_o !== 32'd16) begin
            n_errors++;
            $display("FAIL contention_perf_16: got %0d want 16", perf_hold_cnt_o);
        end
`endif
    endtask

    task automatic test_early_exit();
        do_reset();
        for (int c = 0; c < 4 + 3; c++) begin
            drive(1, 0, 32'h40, 0, 1, 1, 32'h80 + c, c, 0);
            tick();
        end
        drive(1, 0, 32'h40, 0, 0, 0, 0, 0, 32'hAA);
        n_checks++;
        if (core_hold_o !== 1'b1 || ext_gnt_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL early_exit_drop: got hold=%b gnt=%b req=%b want 1 0 0",
                     core_hold_o, ext_gnt_o, mem_req_o);
        end
        tick();
        drive(1, 0, 32'h40, 0, 0, 0, 0, 0, 32'hBB);
        n_checks++;
        if (core_hold_o !== 1'b0 || core_rdata_o !== 32'hBB) begin
            n_errors++;
            $display("FAIL early_exit_resume: got hold=%b rdata=%h want 0 bb", core_hold_o, core_rdata_o);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1, 0, 0, 0, 1, 0, 32'h100 + c, 0, 32'hC0 + c);
            tick();
        end
        drive(1, 0, 0, 0, 1, 0, 32'h200, 0, 32'hCAFE);
        n_checks++;
        if (core_hold_o !== 1'b1 || ext_rvalid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL async_pre: got hold=%b rvalid=%b want 1 1", core_hold_o, ext_rvalid_o);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (core_hold_o !== 1'b0 || ext_rvalid_o !== 1'b0 || ext_gnt_o !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got hold=%b rvalid=%b gnt=%b want 0 0 0",
                     core_hold_o, ext_rvalid_o, ext_gnt_o);
        end
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (ext_rvalid_o !== 1'b0 || perf_hold_cnt_o !== 32'h0) begin
            n_errors++;
            $display("FAIL async_after: got rvalid=%b perf=%0d want 0 0", ext_rvalid_o, perf_hold_cnt_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_random();
        bit cr = 0, cw = 0, er = 0, ew = 0;
        logic [31:0] ca = 0, cd = 0, ea = 0, ed = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!m_burst || !cr) begin
                cr = ($urandom_range(99) < 70); cw = 1'($urandom);
                ca = $urandom; cd = $urandom;
            end
            if (!er || exp_gnt) begin
                er = ($urandom_range(99) < 60); ew = 1'($urandom);
                ea = $urandom; ed = $urandom;
            end
            drive(cr, cw, ca, cd, er, ew, ea, ed, $urandom);
            n_checks++;
            if (core_hold_o !== exp_hold || ext_gnt_o !== exp_gnt || mem_req_o !== exp_req
                || mem_we_o !== exp_we) begin
                n_errors++;
                $display("FAIL rand_ctrl_%0d: got hold=%b gnt=%b req=%b we=%b want %b %b %b %b", i,
                         core_hold_o, ext_gnt_o, mem_req_o, mem_we_o, exp_hold, exp_gnt, exp_req, exp_we);
            end
            n_checks++;
            if (mem_waddr_o !== exp_addr || mem_raddr_o !== exp_addr || mem_wdata_o !== exp_wdata
                || core_rdata_o !== exp_crd) begin
                n_errors++;
                $display("FAIL rand_data_%0d: got wa=%h ra=%h wd=%h crd=%h want %h %h %h %h", i,
                         mem_waddr_o, mem_raddr_o, mem_wdata_o, core_rdata_o,
                         exp_addr, exp_addr, exp_wdata, exp_crd);
            end
            n_checks++;
            if (ext_rvalid_o !== m_rvalid || ext_rdata_o !== m_rdata) begin
                n_errors++;
                $display("FAIL rand_ext_rd_%0d: got rvalid=%b rdata=%h want %b %h", i,
                         ext_rvalid_o, ext_rdata_o, m_rvalid, m_rdata);
            end
            n_checks++;
            if (perf_hold_cnt_o !== exp_perf_hold || perf_wait_cnt_o !== exp_perf_wait) begin
                n_errors++;
                $display("FAIL rand_perf_%0d: got hold=%0d wait=%0d want %0d %0d", i,
                         perf_hold_cnt_o, perf_wait_cnt_o, exp_perf_hold, exp_perf_wait);
            end
            tick();
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_core_read();
        test_ext_read();
        test_contention();
        test_early_exit();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
